lmdpl_nor_seq: RTL

- Sequencer for one LMDPL masked NOR gate instance.
- For each operation it:
  - draws fresh masks (m_in0, m_in1, m_out) from an internal LFSR;
  - holds the gate in precharge while the mask-dependent truth table settles;
  - opens the evaluate window;
  - captures the unmasked gate result.
- Sits between a requester (start/done handshake) and the nor_lmdpl datapath; drives its precharge, operand and mask inputs.

---
 rtl/lmdpl_nor_seq_if.sv | 38 +++
 rtl/lmdpl_nor_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/lmdpl_nor_seq_if.sv
// lmdpl_nor_seq_if
// Bundles the two sides of the LMDPL NOR sequencer:
//   requester side : start, in0, in1, reseed, seed -> busy, done, out
//   gate side      : precharge, g_in0, g_in1, m_in0, m_in1, m_out -> g_out
// Modports:
//   slave  - the sequencer (receives requests, drives the gate)
//   master - the requester together with the gate datapath
// Handshake: start is a level sampled on a rising edge while busy is low.
// The operation it launches ends with a one-cycle done pulse, and out is
// valid from that cycle until the next capture. While busy is high, start,
// reseed and the operands are ignored and never queued.
interface lmdpl_nor_seq_if;
  logic        start;
  logic        in0;
  logic        in1;
  logic        reseed;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic        out;
  logic        precharge;
  logic        g_in0;
  logic        g_in1;
  logic        m_in0;
  logic        m_in1;
  logic        m_out;
  logic        g_out;

  modport slave (
    input  start, in0, in1, reseed, seed, g_out,
    output busy, done, out, precharge, g_in0, g_in1, m_in0, m_in1, m_out
  );

  modport master (
    output start, in0, in1, reseed, seed, g_out,
    input  busy, done, out, precharge, g_in0, g_in1, m_in0, m_in1, m_out
  );
endinterface

// File: rtl/lmdpl_nor_seq.sv
// lmdpl_nor_seq
// Sequences one LMDPL masked NOR gate. Each operation draws fresh masks
// from a 16-bit Fibonacci LFSR, holds the gate in precharge for PRE_CYCLES,
// opens the evaluate window for EVAL_CYCLES and captures the unmasked
// result on the last evaluate cycle.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   sif       - slave side of lmdpl_nor_seq_if (requester and gate signals)
//   dbg_state - current FSM state encoding, for observation only
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module lmdpl_nor_seq #(
  parameter int          PRE_CYCLES  = 2,
  parameter int          EVAL_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lmdpl_nor_seq_if.slave       sif,
  output logic [2:0]           dbg_state
);

  localparam int MAX_CYCLES = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MASK = 3'd1,
    PRE  = 3'd2,
    EVAL = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [15:0]   seed_val;
  logic          g_in0_q, g_in1_q;
  logic          m_in0_q, m_in1_q, m_out_q;
  logic          out_q;

  // x^16+x^14+x^13+x^11+1, maximal length, so a nonzero state stays nonzero.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    seed_val  = (sif.seed == 16'd0) ? LFSR_SEED : sif.seed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      g_in0_q <= 1'b0;
      g_in1_q <= 1'b0;
      m_in0_q <= 1'b0;
      m_in1_q <= 1'b0;
      m_out_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // start has priority; a simultaneous reseed is dropped.
          if (sif.start) begin
            g_in0_q <= sif.in0;
            g_in1_q <= sif.in1;
            state   <= MASK;
          end else if (sif.reseed) begin
            lfsr <= seed_val;
          end
        end
        MASK: begin
          // Masks come from the stepped value and hold until the next MASK.
          lfsr    <= lfsr_next;
          m_in0_q <= lfsr_next[0];
          m_in1_q <= lfsr_next[1];
          m_out_q <= lfsr_next[2];
          cnt     <= '0;
          state   <= PRE;
        end
        PRE: begin
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          if (cnt == EVAL_LAST) begin
            out_q <= sif.g_out;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.busy      = (state != IDLE);
  assign sif.done      = (state == DONE);
  assign sif.precharge = (state != EVAL);
  assign sif.out       = out_q;
  assign sif.g_in0     = g_in0_q;
  assign sif.g_in1     = g_in1_q;
  assign sif.m_in0     = m_in0_q;
  assign sif.m_in1     = m_in1_q;
  assign sif.m_out     = m_out_q;
  assign dbg_state     = state;

endmodule
